ion_sensor_arbiter: RTL and testbench

Shares the single ion-sensor read datapath between the eight per-stream request lines from the ion sensor requester. Request pulses are latched as pending bits. One pending stream at a time is granted, in round-robin order. The arbiter issues a start pulse with the stream ID and holds off further grants until the datapath returns done or a timeout expires. Lost requests (overruns) and timeouts are flagged for the status/control logic.

---
 rtl/ion_sensor_arbiter.sv | 118 +++++++++++
 tb/tb_ion_sensor_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ion_sensor_arbiter.sv
// Round-robin arbiter sharing the single ion-sensor read datapath among eight
// request streams, with overrun tracking and an optional WAIT timeout.
module ion_sensor_arbiter #(
    parameter logic [15:0] TIMEOUT  = 16'd50000,
    parameter logic [2:0]  FIRST_ID = 3'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] stream_active,
    input  logic [7:0] i_s_request,
    input  logic       sensor_done,
    input  logic       clear_overrun,
    output logic       issue,
    output logic [2:0] grant_id,
    output logic       busy,
    output logic [7:0] pending,
    output logic [7:0] overrun,
    output logic       timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  grant_nxt;
    logic [2:0]  last, last_nxt;
    logic [15:0] timer, timer_nxt;
    logic        issue_nxt;
    logic        tout_nxt;
    logic [7:0]  grant_clear;
    logic [7:0]  pending_nxt;
    logic [7:0]  overrun_nxt;
    logic        found;
    logic [2:0]  pick;
    logic [2:0]  idx;

    // Scan last+1 .. last+8 so the stream granted most recently goes last.
    always_comb begin
        found = 1'b0;
        pick  = last;
        idx   = last;
        for (int off = 1; off <= 8; off++) begin
            idx = last + 3'(off);
            if (!found && pending[idx] && stream_active[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // A request in the same cycle as its grant-clear keeps the bit set and is not an overrun.
    always_comb begin
        grant_clear = (state == ISSUE) ? (8'b1 << grant_id) : 8'b0;
        pending_nxt = stream_active & (i_s_request | (pending & ~grant_clear));
        overrun_nxt = (clear_overrun ? 8'b0 : overrun)
                    | (i_s_request & stream_active & pending & ~grant_clear);
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        last_nxt  = last;
        timer_nxt = timer;
        issue_nxt = 1'b0;
        tout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = pick;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                issue_nxt = 1'b1;
                timer_nxt = 16'd0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // Done takes priority over a timeout landing on the same edge.
                if (sensor_done) begin
                    last_nxt  = grant_id;
                    state_nxt = IDLE;
                end else if ((TIMEOUT != 16'd0) && (timer == TIMEOUT - 16'd1)) begin
                    tout_nxt  = 1'b1;
                    last_nxt  = grant_id;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant_id    <= 3'd0;
            last        <= FIRST_ID - 3'd1;
            timer       <= 16'd0;
            issue       <= 1'b0;
            timeout_err <= 1'b0;
            pending     <= 8'd0;
            overrun     <= 8'd0;
        end else begin
            state       <= state_nxt;
            grant_id    <= grant_nxt;
            last        <= last_nxt;
            timer       <= timer_nxt;
            issue       <= issue_nxt;
            timeout_err <= tout_nxt;
            pending     <= pending_nxt;
            overrun     <= overrun_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ion_sensor_arbiter.sv
// Scoreboard bench for ion_sensor_arbiter: expected grant IDs are queued as
// requests are issued and a monitor pops them on every issue pulse.
module tb_ion_sensor_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] stream_active;
    logic [7:0] i_s_request;
    logic       sensor_done;
    logic       clear_overrun;
    logic       issue;
    logic [2:0] grant_id;
    logic       busy;
    logic [7:0] pending;
    logic [7:0] overrun;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    logic [2:0] expectQ[$];

    ion_sensor_arbiter #(.TIMEOUT(16'd10), .FIRST_ID(3'd0)) dut (
        .clock(clock), .reset(reset), .stream_active(stream_active),
        .i_s_request(i_s_request), .sensor_done(sensor_done),
        .clear_overrun(clear_overrun), .issue(issue), .grant_id(grant_id),
        .busy(busy), .pending(pending), .overrun(overrun),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    // Every issue pulse must match the oldest queued grant.
    always @(negedge clock) begin
        if (issue) begin
            checks++;
            if (expectQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_issue grant_id=%0d with empty scoreboard", grant_id);
            end else begin
                logic [2:0] exp_id;
                exp_id = expectQ.pop_front();
                if (grant_id !== exp_id) begin
                    errors++;
                    $display("[TB] FAIL grant_order got=%0d expected=%0d", grant_id, exp_id);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] req);
        i_s_request = req;
        tick();
        i_s_request = 8'h00;
    endtask

    task automatic awaitIssue();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (issue === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL issue_timeout got=no_issue expected=issue within 20 cycles");
        end
    endtask

    task automatic pulseDone();
        sensor_done = 1'b1;
        tick();
        sensor_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        stream_active = 8'hFF;
        i_s_request = 8'h00;
        sensor_done = 1'b0;
        clear_overrun = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("reset_busy", 16'(busy), 16'd0);
        checkOutput("reset_pending", 16'(pending), 16'h00);
        checkOutput("reset_overrun", 16'(overrun), 16'h00);
        checkOutput("reset_grant_id", 16'(grant_id), 16'd0);

        // Single request on stream 2: issue lands two edges after pending.
        expectQ.push_back(3'd2);
        applyStimulus(8'h04);
        checkOutput("single_pending", 16'(pending), 16'h04);
        tick();
        checkOutput("single_issue_not_yet", 16'(issue), 16'd0);
        tick();
        checkOutput("single_issue", 16'(issue), 16'd1);
        checkOutput("single_busy", 16'(busy), 16'd1);
        pulseDone();
        checkOutput("single_idle", 16'(busy), 16'd0);
        checkOutput("single_pending_clear", 16'(pending), 16'h00);

        // Move the pointer to 0, then 8'h81 must grant 7 before 0.
        expectQ.push_back(3'd0);
        applyStimulus(8'h01);
        awaitIssue();
        pulseDone();
        expectQ.push_back(3'd7);
        expectQ.push_back(3'd0);
        applyStimulus(8'h81);
        awaitIssue();
        pulseDone();
        awaitIssue();
        pulseDone();
        expectQ.push_back(3'd1);
        expectQ.push_back(3'd0);
        applyStimulus(8'h03);
        awaitIssue();
        pulseDone();
        awaitIssue();
        pulseDone();

        // Overrun on stream 3 while stream 5 waits.
        expectQ.push_back(3'd5);
        applyStimulus(8'h20);
        awaitIssue();
        applyStimulus(8'h08);
        tick();
        applyStimulus(8'h08);
        checkOutput("overrun_set", 16'(overrun), 16'h08);
        checkOutput("overrun_pending", 16'(pending), 16'h08);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        checkOutput("overrun_cleared", 16'(overrun), 16'h00);
        clear_overrun = 1'b1;
        applyStimulus(8'h08);
        clear_overrun = 1'b0;
        checkOutput("overrun_set_beats_clear", 16'(overrun), 16'h08);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        expectQ.push_back(3'd3);
        pulseDone();
        awaitIssue();
        pulseDone();

        // Timeout on stream 6, then stream 1 granted; then done on the timeout edge.
        expectQ.push_back(3'd6);
        expectQ.push_back(3'd1);
        applyStimulus(8'h42);
        awaitIssue();
        for (int i = 0; i < 9; i++) tick();
        checkOutput("timeout_not_early", 16'(timeout_err), 16'd0);
        tick();
        checkOutput("timeout_pulse", 16'(timeout_err), 16'd1);
        checkOutput("timeout_idle", 16'(busy), 16'd0);
        awaitIssue();
        for (int i = 0; i < 9; i++) tick();
        pulseDone();
        checkOutput("done_beats_timeout", 16'(timeout_err), 16'd0);
        checkOutput("done_beats_timeout_idle", 16'(busy), 16'd0);

        // Masking a pending stream clears it before it can be granted.
        applyStimulus(8'h10);
        checkOutput("mask_pending_before", 16'(pending), 16'h10);
        stream_active = 8'hEF;
        tick();
        checkOutput("mask_pending_after", 16'(pending), 16'h00);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("mask_no_grant", 16'(busy), 16'd0);
        stream_active = 8'hFF;

        // Masking the granted stream in WAIT does not abort the read.
        expectQ.push_back(3'd2);
        applyStimulus(8'h04);
        awaitIssue();
        stream_active = 8'hFB;
        tick();
        tick();
        checkOutput("mask_wait_busy", 16'(busy), 16'd1);
        pulseDone();
        checkOutput("mask_wait_done", 16'(busy), 16'd0);
        stream_active = 8'hFF;

        // Async reset mid-WAIT with pending and overrun populated.
        expectQ.push_back(3'd7);
        applyStimulus(8'h80);
        awaitIssue();
        applyStimulus(8'h10);
        applyStimulus(8'h10);
        checkOutput("pre_reset_overrun", 16'(overrun), 16'h10);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_busy", 16'(busy), 16'd0);
        checkOutput("async_reset_grant_id", 16'(grant_id), 16'd0);
        checkOutput("async_reset_pending", 16'(pending), 16'h00);
        checkOutput("async_reset_overrun", 16'(overrun), 16'h00);
        checkOutput("async_reset_issue", 16'(issue), 16'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("post_reset_idle", 16'(busy), 16'd0);
        checkOutput("scoreboard_drained", 16'(expectQ.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
